// File: rtl/hamming_corrector.sv
// hamming_corrector: two-stage Hamming (7,4) single-error corrector with valid/ready flow
// control and a saturating count of corrected words.
module hamming_corrector #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       code_in,
    input  logic [2:0]       syndrome_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       data_out,
    output logic             err_flag,
    output logic [2:0]       err_pos,
    output logic             par_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_count
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic       adv;
    logic       s1_valid;
    logic [3:0] s1_data;
    logic [2:0] s1_syn;
    logic [6:0] flip;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Check bits never reach the output, so only the position of a check-bit flip matters.
    always_comb begin
        flip = s1_syn == 3'b110 ? 7'h01 :
               s1_syn == 3'b101 ? 7'h02 :
               s1_syn == 3'b011 ? 7'h04 :
               s1_syn == 3'b111 ? 7'h08 :
               s1_syn == 3'b001 ? 7'h10 :
               s1_syn == 3'b010 ? 7'h20 :
               s1_syn == 3'b100 ? 7'h40 : 7'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_syn     <= '0;
            out_valid  <= 1'b0;
            data_out   <= '0;
            err_flag   <= 1'b0;
            err_pos    <= '0;
            par_err    <= 1'b0;
            corr_count <= '0;
        end else begin
            if (adv) begin
                s1_valid  <= in_valid;
                out_valid <= s1_valid;
                if (in_valid) begin
                    s1_data <= code_in[3:0];
                    s1_syn  <= syndrome_in ^ code_in[6:4];
                end
                if (s1_valid) begin
                    data_out <= s1_data ^ flip[3:0];
                    err_flag <= |s1_syn;
                    err_pos  <= s1_syn;
                    par_err  <= |flip[6:4];
                end
            end
            if (cnt_clr)
                corr_count <= '0;
            else if (adv && s1_valid && |s1_syn && !(&corr_count))
                corr_count <= corr_count + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_hamming_corrector.sv
// tb_hamming_corrector: randomized scoreboard bench for hamming_corrector, plus a
// CNT_W=2 instance for saturation, clear priority and mid-stream reset.
module tb_hamming_corrector;
    typedef struct packed {
        logic [3:0] d;
        logic [2:0] p;
        logic       par;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [6:0] code_in = '0;
    logic [2:0] syndrome_in = '0;
    logic [3:0] data_out;
    logic err_flag, par_err, cnt_clr = 1'b0;
    logic [2:0] err_pos;
    logic [15:0] corr_count;

    logic s_rst = 1'b1;
    logic s_in_valid = 1'b0, s_in_ready, s_out_valid, s_err_flag, s_par_err, s_cnt_clr = 1'b0;
    logic [6:0] s_code = '0;
    logic [2:0] s_syn = '0, s_err_pos;
    logic [3:0] s_data_out;
    logic [1:0] s_corr_count;

    int vectors = 0, miscompares = 0, delivered = 0;
    bit rand_ready = 1'b0, hold = 1'b0;
    logic [9:0] prev;
    exp_t cur_exp, q[$];

    always #5 clk = ~clk;

    hamming_corrector #(.CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .code_in(code_in), .syndrome_in(syndrome_in), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .err_flag(err_flag),
        .err_pos(err_pos), .par_err(par_err), .cnt_clr(cnt_clr), .corr_count(corr_count)
    );

    hamming_corrector #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .code_in(s_code), .syndrome_in(s_syn), .out_valid(s_out_valid),
        .out_ready(1'b1), .data_out(s_data_out), .err_flag(s_err_flag),
        .err_pos(s_err_pos), .par_err(s_par_err), .cnt_clr(s_cnt_clr), .corr_count(s_corr_count)
    );

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Syndrome column of each code bit: data bits first, then p0..p2.
    function automatic logic [2:0] col(input int i);
        case (i)
            0: return 3'b110;
            1: return 3'b101;
            2: return 3'b011;
            3: return 3'b111;
            4: return 3'b001;
            5: return 3'b010;
            6: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] chk_bits(input logic [3:0] d);
        logic [2:0] c = '0;
        for (int i = 0; i < 4; i++)
            if (d[i]) c ^= col(i);
        return c;
    endfunction

    // Encode d, flip bit k (k=7: clean), and derive what the upstream syndrome block sends.
    task automatic gen(input logic [3:0] d, input int k, output logic [6:0] code,
                       output logic [2:0] syn, output exp_t e);
        code = {chk_bits(d), d};
        if (k < 7) code[k] = ~code[k];
        syn = chk_bits(code[3:0]);
        e.d = d;
        e.p = col(k);
        e.par = k >= 4 && k < 7;
    endtask

    task automatic send(input logic [6:0] code, input logic [2:0] syn, input exp_t e);
        bit acc;
        in_valid = 1'b1;
        code_in = code;
        syndrome_in = syn;
        cur_exp = e;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            if (n > 1000) begin
                chk_eq("accept_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] d, input int k);
        logic [6:0] c;
        logic [2:0] s;
        exp_t e;
        gen(d, k, c, s, e);
        send(c, s, e);
    endtask

    task automatic drain();
        for (int n = 0; n < 1000 && q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        chk_eq("drain_empty", q.size(), 0);
    endtask

    task automatic s_step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold = 1'b0;
        end else begin
            chk_eq("in_ready_rule", in_ready, !out_valid || out_ready);
            if (hold) chk_eq("stall_hold", {out_valid, data_out, err_flag, err_pos, par_err}, prev);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk_eq("spurious_out", out_valid, 0);
                end else begin
                    e = q[0];
                    chk_eq("data_out", data_out, e.d);
                    chk_eq("err_pos", err_pos, e.p);
                    chk_eq("err_flag", err_flag, e.p != 0);
                    chk_eq("par_err", par_err, e.par);
                    if (out_ready) begin
                        void'(q.pop_front());
                        if (e.p != 0) delivered++;
                        chk_eq("corr_count", corr_count, delivered);
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(cur_exp);
            hold = out_valid && !out_ready;
            prev = {out_valid, data_out, err_flag, err_pos, par_err};
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = $urandom_range(0, 3) != 0;
    end

    initial begin
        logic [6:0] c;
        logic [2:0] s;
        exp_t e;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        s_rst = 1'b0;
        @(negedge clk);
        chk_eq("rst_out_valid", out_valid, 0);
        chk_eq("rst_in_ready", in_ready, 1);
        chk_eq("rst_outputs", {data_out, err_flag, err_pos, par_err}, 0);
        chk_eq("rst_count", corr_count, 0);
        chk_eq("rst_sat_state", {s_in_ready, s_out_valid, s_corr_count}, 4'b1000);

        gen(4'hB, 1, c, s, e);
        chk_eq("model_pin_code", c, 7'h49);
        chk_eq("model_pin_syn", s, 3'b001);
        chk_eq("model_pin_clean", chk_bits(4'hB), 3'b100);

        @(posedge clk);
        #1;
        send(7'h4B, 3'b100, '{d: 4'hB, p: 3'b000, par: 1'b0});
        @(negedge clk);
        chk_eq("t1_lat_early", out_valid, 0);
        @(negedge clk);
        chk_eq("t1_lat_valid", out_valid, 1);
        chk_eq("t1_data", {data_out, err_flag, err_pos}, {4'hB, 1'b0, 3'b000});
        chk_eq("t1_count", corr_count, 0);
        @(posedge clk);
        #1;
        send(7'h49, 3'b001, '{d: 4'hB, p: 3'b101, par: 1'b0});
        @(negedge clk);
        @(negedge clk);
        chk_eq("t2_data", {out_valid, data_out, err_pos, par_err}, {1'b1, 4'hB, 3'b101, 1'b0});
        chk_eq("t2_count", corr_count, 1);
        @(posedge clk);
        #1;
        send(7'h0B, 3'b100, '{d: 4'hB, p: 3'b100, par: 1'b1});
        @(negedge clk);
        @(negedge clk);
        chk_eq("t3_data", {out_valid, data_out, err_pos, par_err}, {1'b1, 4'hB, 3'b100, 1'b1});
        chk_eq("t3_count", corr_count, 2);
        @(posedge clk);
        #1;

        rand_ready = 1'b1;
        for (int d = 0; d < 16; d++)
            for (int k = 0; k < 8; k++)
                send_word(4'(d), k);
        drain();
        chk_eq("sweep_count", corr_count, 114);

        rand_ready = 1'b0;
        out_ready = 1'b0;
        fork
            for (int i = 0; i < 6; i++) send_word(4'($urandom_range(0, 15)), $urandom_range(0, 7));
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                chk_eq("bp_in_ready", in_ready, 0);
                chk_eq("bp_out_valid", out_valid, 1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send_word(4'($urandom_range(0, 15)), $urandom_range(0, 7));
        end
        drain();
        rand_ready = 1'b0;
        out_ready = 1'b1;

        s_in_valid = 1'b1;
        s_code = 7'h49;
        s_syn = 3'b001;
        repeat (5) s_step();
        s_in_valid = 1'b0;
        repeat (3) s_step();
        @(negedge clk);
        chk_eq("sat_count", s_corr_count, 3);
        s_step();
        s_in_valid = 1'b1;
        s_step();
        s_in_valid = 1'b0;
        s_cnt_clr = 1'b1;
        s_step();
        s_cnt_clr = 1'b0;
        @(negedge clk);
        chk_eq("clr_load_same_cycle", {s_out_valid, s_err_flag}, 2'b11);
        chk_eq("clr_wins", s_corr_count, 0);
        s_step();
        s_in_valid = 1'b1;
        repeat (3) s_step();
        @(negedge clk);
        chk_eq("pre_rst_valid", s_out_valid, 1);
        chk_eq("pre_rst_count", s_corr_count, 2);
        s_step();
        s_rst = 1'b1;
        s_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_eq("rst_mid_valid", s_out_valid, 0);
        chk_eq("rst_mid_state", {s_data_out, s_err_flag, s_corr_count}, 0);
        s_step();
        s_rst = 1'b0;
        @(negedge clk);
        chk_eq("rst_no_partial1", s_out_valid, 0);
        @(negedge clk);
        chk_eq("rst_no_partial2", s_out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
